// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the chunked serial subtractor.
// Holds the FSM state encoding and the counter-width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_nbit_sub_chunk.sv
// Combinational CHUNK-bit ripple-borrow subtractor.
// Built from full-subtractor bit slices.
module sub_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] c;

    assign c[0] = bin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign d[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
    end

    assign bout = c[CHUNK];

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Multi-cycle subtractor: a - b - borrow_in, CHUNK bits per clock.
// Borrow ripples between cycles through a registered flop.
module serial_subtractor_nbit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    sub_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] sx, sy, sd;
    logic             sbout;
    logic             last;

    assign sx   = op_a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign sy   = op_b_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign last = (cnt_q == CW'(NCHUNK - 1));

    sub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x   (sx),
        .y   (sy),
        .bin (brw_q),
        .d   (sd),
        .bout(sbout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                    diff_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[int'(cnt_q)*CHUNK +: CHUNK] = sd;
                brw_d = sbout;
                if (last) begin
                    // Flags use the just-completed result.
                    bout_d  = sbout;
                    ovf_d   = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != op_a_q[WIDTH-1]);
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
Parametrised multi-cycle subtractor: computes a - b - borrow_in on WIDTH-bit operands, CHUNK bits per clock, rippling the borrow between cycles through a registered borrow flop.
Successor to the 1-bit gate-level half subtractor. Adds operand width, a borrow input, signed overflow and zero flags, and valid/ready handshakes on both sides.
Used as an area-cheap subtraction engine in datapaths where latency is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2 and an integer multiple of CHUNK
CHUNK, 2, bits processed per cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived localparam (not overridable); number of compute cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  borrow into LSB
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
borrow_out  output  1  unsigned borrow: 1 iff a < b + borrow_in
overflow  output  1  two's-complement overflow of the subtraction
zero  output  1  1 iff diff == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state = IDLE; all registers cleared to 0.
  - Outputs during reset: in_ready = 1, out_valid = 0, diff = 0, borrow_out = 0, overflow = 0, zero = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: latch a, b, borrow_in into op_a, op_b, brw; clear cnt and the diff register; go to BUSY.
  - Input values are sampled only at this edge. Later changes to a, b or borrow_in are ignored.
- BUSY (per cycle, cnt = 0..NCHUNK-1):
  - slice = op_a[cnt*CHUNK +: CHUNK] - op_b[same] - brw.
  - The chunk result is written into diff[same]; its borrow is registered into brw.
  - cnt increments. On the edge where cnt == NCHUNK-1, go to DONE.
  - in_ready = 0; in_valid is ignored.
- Latency: accept at edge k, out_valid high after edge k+NCHUNK.
  - CHUNK = WIDTH gives 1 compute cycle; CHUNK = 1 gives WIDTH compute cycles.
- Flag registers, updated on the DONE-entry edge:
  - borrow_out = final brw.
  - overflow = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]).
  - zero = (diff == 0).
- DONE:
  - out_valid = 1. diff and all flags are held stable until out_ready.
  - On out_valid && out_ready at an edge: go to IDLE. out_valid drops after that edge.
  - diff and flags retain their values in IDLE until the next accept clears diff.
  - No same-cycle re-accept: in_ready = 0 while in DONE.
- out_ready is ignored outside DONE. out_ready held permanently high gives exactly one DONE cycle per operation.
- Reset asserted mid-operation (BUSY or DONE):
  - Immediate abort; all state and outputs take their reset values.
  - The pending result is discarded; no partial output is ever flagged valid.
- cnt width: clog2(NCHUNK) bits, minimum 1. cnt never exceeds NCHUNK-1.

Decomposition:
- Package serial_sub_pkg:
  - state enum / localparams for IDLE, BUSY, DONE.
  - function computing cnt width from NCHUNK.
- Sub-module sub_chunk (combinational, parameter CHUNK):
  - ripple of CHUNK full-subtractor bit slices.
  - inputs: x[CHUNK], y[CHUNK], bin; outputs: d[CHUNK], bout.
  - bit slice: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
  - Instantiated once and reused each cycle.

Test Plan:
(All scenarios use WIDTH=8, CHUNK=2 unless stated.)
- Basic: a=0x35, b=0x12, bin=0 -> diff=0x23, borrow_out=0, overflow=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- Unsigned borrow: a=0x12, b=0x35, bin=0 -> diff=0xDD, borrow_out=1, overflow=0.
- Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow_out=0, overflow=1.
- Zero with borrow_in: a=0x05, b=0x04, bin=1 -> diff=0x00, zero=1, borrow_out=0.
- Backpressure: hold out_ready=0 for 3 DONE cycles while driving in_valid=1 with a=0xFF, b=0x00 -> in_ready=0 and diff/flags unchanged throughout; that second operand is never accepted.
- Reset and parameter sweep:
  - Assert rst_n=0 during BUSY cycle 2 -> all outputs 0 and in_ready=1 immediately; a following 0x35-0x12 returns 0x23.
  - Repeat the basic case with CHUNK=1 -> latency 8; with CHUNK=8 -> latency 1; identical results.
